// File: rtl/vec_mem_sequencer.sv
// ============================================================================
// Module   : vec_mem_sequencer
// Brief    : Serialises one scalar/vector load or store into byte-wide
//            accesses on a single-port data memory; pulses done_o at the end.
//            Optional range check enabled by defining VMS_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_mem_sequencer #(
    parameter int I         = 20,
    parameter int L         = 8,
    parameter int A         = 32,
    parameter int MEM_DEPTH = 4096
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start_i,
    input  logic           vector_i,
    input  logic           write_i,
    input  logic [A-1:0]   address_i,
    input  logic [I*L-1:0] wdata_v_i,
    input  logic [L-1:0]   wdata_s_i,
    input  logic [L-1:0]   mem_rdata_i,
    output logic [A-1:0]   mem_addr_o,
    output logic [L-1:0]   mem_wdata_o,
    output logic           mem_we_o,
    output logic [I*L-1:0] rdata_v_o,
    output logic [L-1:0]   rdata_s_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    localparam int c_k_w = (I > 1) ? $clog2(I) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [c_k_w-1:0]   r_k;
    logic [c_k_w-1:0]   r_last;
    logic               r_vec;
    logic [A-1:0]       r_base;
    logic [L-1:0]       r_wlane  [I];
    logic [L-1:0]       r_gather [I];
    logic [L-1:0]       r_rdv    [I];
    logic [L-1:0]       r_rds;
    logic [A-1:0]       r_addr;
    logic [L-1:0]       r_wdata;
    logic               r_we;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [c_k_w-1:0]   w_k_next;
    logic [c_k_w-1:0]   w_k_prev;
    logic [A-1:0]       w_addr_next;
    logic               w_range_err;

    assign w_k_next    = r_k + c_k_w'(1);
    assign w_k_prev    = r_k - c_k_w'(1);
    assign w_addr_next = r_base + A'(w_k_next);

`ifdef VMS_RANGE_CHECK_EN
    logic [A:0] w_last_addr;
    // One extra bit so a request running past 2^A-1 is still caught.
    assign w_last_addr = {1'b0, address_i} + (A+1)'(vector_i ? I - 1 : 0);
    assign w_range_err = (w_last_addr > (A+1)'(MEM_DEPTH - 1));
`else
    assign w_range_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_last  <= '0;
            r_vec   <= 1'b0;
            r_base  <= '0;
            r_rds   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int j = 0; j < I; j++) begin
                r_wlane[j]  <= '0;
                r_gather[j] <= '0;
                r_rdv[j]    <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_busy <= 1'b1;
                        r_k    <= '0;
                        r_vec  <= vector_i;
                        r_base <= address_i;
                        r_last <= vector_i ? c_k_w'(I - 1) : '0;
                        for (int j = 0; j < I; j++)
                            r_wlane[j] <= wdata_v_i[j*L +: L];
                        if (!vector_i)
                            r_wlane[0] <= wdata_s_i;
                        if (w_range_err) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= write_i ? S_WRITE : S_READ;
                            r_addr  <= address_i;
                            r_we    <= write_i;
                            r_wdata <= write_i ? (vector_i ? wdata_v_i[L-1:0] : wdata_s_i) : '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_k == r_last) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_addr  <= '0;
                        r_wdata <= '0;
                        r_we    <= 1'b0;
                    end else begin
                        r_k     <= w_k_next;
                        r_addr  <= w_addr_next;
                        r_wdata <= r_wlane[w_k_next];
                    end
                end
                S_READ: begin
                    // Read data lags the address by one cycle.
                    if (r_k != '0)
                        r_gather[w_k_prev] <= mem_rdata_i;
                    if (r_k == r_last) begin
                        r_state <= S_DRAIN;
                        r_addr  <= '0;
                    end else begin
                        r_k    <= w_k_next;
                        r_addr <= w_addr_next;
                    end
                end
                S_DRAIN: begin
                    // Visible load outputs change only on completion.
                    if (r_vec) begin
                        for (int j = 0; j < I; j++)
                            r_rdv[j] <= (j == I - 1) ? mem_rdata_i : r_gather[j];
                    end else begin
                        r_rds <= mem_rdata_i;
                    end
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_k     <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_wdata <= '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < I; g++) begin : g_lane_out
        assign rdata_v_o[g*L +: L] = r_rdv[g];
    end

    assign rdata_s_o   = r_rds;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign mem_we_o    = r_we;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vec_mem_sequencer.sv
// ============================================================================
// Module   : tb_vec_mem_sequencer
// Brief    : Directed self-checking bench for vec_mem_sequencer with a
//            registered-read byte memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_mem_sequencer;

    localparam int c_i = 20;
    localparam int c_l = 8;
    localparam int c_a = 32;

    logic                 clk;
    logic                 rst;
    logic                 start_i;
    logic                 vector_i;
    logic                 write_i;
    logic [c_a-1:0]       address_i;
    logic [c_i*c_l-1:0]   wdata_v_i;
    logic [c_l-1:0]       wdata_s_i;
    logic [c_l-1:0]       mem_rdata_i;
    logic [c_a-1:0]       mem_addr_o;
    logic [c_l-1:0]       mem_wdata_o;
    logic                 mem_we_o;
    logic [c_i*c_l-1:0]   rdata_v_o;
    logic [c_l-1:0]       rdata_s_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;

    int n_tests;
    int n_fail;

    vec_mem_sequencer #(.I(c_i), .L(c_l), .A(c_a), .MEM_DEPTH(4096)) dut (
        .CLK(clk), .RST(rst), .start_i(start_i), .vector_i(vector_i),
        .write_i(write_i), .address_i(address_i), .wdata_v_i(wdata_v_i),
        .wdata_s_i(wdata_s_i), .mem_rdata_i(mem_rdata_i),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .rdata_v_o(rdata_v_o), .rdata_s_o(rdata_s_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port byte memory, data registered one cycle after the address.
    logic [7:0] mem [4096];
    always @(posedge clk) begin
        if (mem_we_o)
            mem[mem_addr_o[11:0]] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o[11:0]];
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Per-request observations, filled by observe().
    int           we_cnt, we_first, we_last, done_cyc, done_cnt, busy_cnt, wr_bad;
    logic         err_at_done;
    logic [159:0] rdv_at_done;
    logic [7:0]   exp_lane [c_i];
    logic [159:0] vec_1_20;
    logic [159:0] lanes_tmp;

    task automatic drive_req(input logic vec, input logic wr, input logic [31:0] addr,
                             input logic [159:0] wv, input logic [7:0] ws, input logic hold);
        @(negedge clk);
        start_i   = 1'b1;
        vector_i  = vec;
        write_i   = wr;
        address_i = addr;
        wdata_v_i = wv;
        wdata_s_i = ws;
        @(posedge clk);
        #1;
        if (!hold) start_i = 1'b0;
    endtask

    task automatic observe(input int max_cyc, input logic [31:0] base);
        we_cnt = 0; we_first = 0; we_last = 0; done_cyc = 0; done_cnt = 0;
        busy_cnt = 0; wr_bad = 0; err_at_done = 1'b0; rdv_at_done = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (busy_o) busy_cnt++;
            if (mem_we_o) begin
                we_cnt++;
                if (we_first == 0) we_first = c;
                we_last = c;
                if (mem_addr_o !== base + 32'(c - 1) || mem_wdata_o !== exp_lane[(c - 1) % c_i])
                    wr_bad++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc    = c;
                    err_at_done = err_o;
                    rdv_at_done = rdata_v_o;
                end
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b0; start_i = 1'b0; vector_i = 1'b0; write_i = 1'b0;
        address_i = '0; wdata_v_i = '0; wdata_s_i = '0;
        for (int j = 0; j < 4096; j++) mem[j] = 8'h00;
        vec_1_20 = '0;
        for (int j = 0; j < c_i; j++) begin
            exp_lane[j] = 8'(j + 1);
            vec_1_20[j*8 +: 8] = 8'(j + 1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 160'(busy_o), 160'(0));
        chk("reset_done", 160'(done_o), 160'(0));
        chk("reset_we", 160'(mem_we_o), 160'(0));
        chk("reset_rdv", rdata_v_o, 160'(0));
        rst = 1'b1;
        @(negedge clk);

        // Vector store, lane k = k+1, base 0x10
        drive_req(1'b1, 1'b1, 32'h10, vec_1_20, 8'h00, 1'b0);
        observe(24, 32'h10);
        chk("vst_we_cnt", 160'(we_cnt), 160'(20));
        chk("vst_we_first", 160'(we_first), 160'(1));
        chk("vst_we_last", 160'(we_last), 160'(20));
        chk("vst_addr_data", 160'(wr_bad), 160'(0));
        chk("vst_done_cyc", 160'(done_cyc), 160'(21));
        chk("vst_done_cnt", 160'(done_cnt), 160'(1));

        // Vector load back
        drive_req(1'b1, 1'b0, 32'h10, '0, 8'h00, 1'b0);
        observe(25, 32'h10);
        chk("vld_done_cyc", 160'(done_cyc), 160'(22));
        chk("vld_busy_cnt", 160'(busy_cnt), 160'(22));
        chk("vld_no_we", 160'(we_cnt), 160'(0));
        chk("vld_rdv_at_done", rdv_at_done, vec_1_20);

        // Scalar store 0xA5 to 0x7, then scalar load
        exp_lane[0] = 8'hA5;
        drive_req(1'b0, 1'b1, 32'h7, '1, 8'hA5, 1'b0);
        observe(5, 32'h7);
        chk("sst_done_cyc", 160'(done_cyc), 160'(2));
        chk("sst_we_cnt", 160'(we_cnt), 160'(1));
        chk("sst_addr_data", 160'(wr_bad), 160'(0));
        drive_req(1'b0, 1'b0, 32'h7, '0, 8'h00, 1'b0);
        observe(5, 32'h7);
        chk("sld_done_cyc", 160'(done_cyc), 160'(3));
        chk("sld_rds", 160'(rdata_s_o), 160'(8'hA5));
        chk("sld_rdv_kept", rdata_v_o, vec_1_20);

        // start_i held through a vector load while inputs change after accept
        drive_req(1'b1, 1'b0, 32'h10, '0, 8'h00, 1'b1);
        vector_i = 1'b0; write_i = 1'b1; address_i = 32'h7; wdata_s_i = 8'h3C;
        we_first = 0; done_cyc = 0; done_cnt = 0; wr_bad = 0; we_cnt = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (mem_we_o) begin
                we_cnt++;
                if (we_first == 0) we_first = c;
                if (mem_addr_o !== 32'h7 || mem_wdata_o !== 8'h3C) wr_bad++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    rdv_at_done = rdata_v_o;
                end else begin
                    we_last = c;
                end
            end
            if (c == 24) start_i = 1'b0;
        end
        chk("hold_first_done", 160'(done_cyc), 160'(22));
        chk("hold_rdv", rdv_at_done, vec_1_20);
        chk("hold_second_we", 160'(we_first), 160'(24));
        chk("hold_second_wr", 160'(wr_bad), 160'(0));
        chk("hold_we_cnt", 160'(we_cnt), 160'(1));
        chk("hold_second_done", 160'(we_last), 160'(25));
        chk("hold_done_cnt", 160'(done_cnt), 160'(2));

        // Reset during cycle 10 of a vector store
        lanes_tmp = '0;
        for (int j = 0; j < c_i; j++) begin
            exp_lane[j] = 8'(8'hE0 + j);
            lanes_tmp[j*8 +: 8] = 8'(8'hE0 + j);
        end
        drive_req(1'b1, 1'b1, 32'h100, lanes_tmp, 8'h00, 1'b0);
        observe(10, 32'h100);
        chk("abort_we_before", 160'(we_cnt), 160'(10));
        chk("abort_wr_before", 160'(wr_bad), 160'(0));
        rst = 1'b0;
        we_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 11; c <= 30; c++) begin
            @(negedge clk);
            if (mem_we_o) we_cnt++;
            if (done_o) done_cnt++;
            if (busy_o) busy_cnt++;
            if (c == 11) begin
                chk("abort_rdv_zero", rdata_v_o, 160'(0));
                chk("abort_rds_zero", 160'(rdata_s_o), 160'(0));
                chk("abort_addr_zero", 160'(mem_addr_o), 160'(0));
            end
            if (c == 13) rst = 1'b1;
        end
        chk("abort_no_we", 160'(we_cnt), 160'(0));
        chk("abort_no_done", 160'(done_cnt), 160'(0));
        chk("abort_no_busy", 160'(busy_cnt), 160'(0));

        // Normal request after the abort
        drive_req(1'b1, 1'b0, 32'h10, '0, 8'h00, 1'b0);
        observe(25, 32'h10);
        chk("post_done_cyc", 160'(done_cyc), 160'(22));
        chk("post_rdv", rdv_at_done, vec_1_20);

        // Vector load near the top of memory
        drive_req(1'b1, 1'b0, 32'd4090, '0, 8'h00, 1'b0);
        observe(25, 32'd4090);
        chk("range_no_we", 160'(we_cnt), 160'(0));
        chk("range_done_cnt", 160'(done_cnt), 160'(1));
`ifdef VMS_RANGE_CHECK_EN
        chk("range_done_cyc", 160'(done_cyc), 160'(1));
        chk("range_err", 160'(err_at_done), 160'(1));
        chk("range_rdv_kept", rdata_v_o, vec_1_20);
`else
        chk("range_done_cyc", 160'(done_cyc), 160'(22));
        chk("range_err", 160'(err_at_done), 160'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
